// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - micro-op dispatch/writeback stage driving the ALU and its register file
module alu_dispatch #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uop_valid,
    output logic       uop_ready,
    input  logic [7:0] uop_op,
    input  logic [2:0] uop_dst,
    input  logic [2:0] uop_src1,
    input  logic [2:0] uop_src2,
    input  logic       uop_imm_en,
    input  logic [7:0] uop_imm,
    input  logic       uop_wide,
    input  logic       uop_setf,
    output logic       alu_enable,
    output logic [7:0] alu_operation,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    output logic       alu_cpu_carry,
    input  logic [7:0] alu_result_l,
    input  logic [7:0] alu_result_h,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_sign,
    output logic [2:0] flags,
    output logic       done,
    input  logic       dbg_wr_en,
    input  logic [2:0] dbg_wr_addr,
    input  logic [7:0] dbg_wr_data,
    input  logic [2:0] dbg_rd_addr,
    output logic [7:0] dbg_rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] regs [8];
    logic [3:0] wait_cnt;
    logic [2:0] dst_q;
    logic       wide_q;
    logic       setf_q;
    logic       dbg_we;
    logic       accept;
    logic [7:0] src1_val;
    logic [7:0] src2_val;

    assign dbg_we        = dbg_wr_en && (state == S_IDLE);
    assign accept        = uop_valid && uop_ready;
    assign alu_cpu_carry = flags[0];
    assign dbg_rd_data   = regs[dbg_rd_addr];

    // Operands are captured on the accepting edge so they are stable for the
    // whole enable cycle; a same-cycle preload is forwarded into them.
    always_comb begin
        src1_val = regs[uop_src1];
        src2_val = regs[uop_src2];
        if (dbg_we && (dbg_wr_addr == uop_src1)) src1_val = dbg_wr_data;
        if (dbg_we && (dbg_wr_addr == uop_src2)) src2_val = dbg_wr_data;
    end

    always_comb begin
        state_next = state;
        uop_ready  = 1'b0;
        alu_enable = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                uop_ready = rst;
                if (uop_valid && rst) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                alu_enable = rst;
                state_next = (ALU_LAT == 1) ? S_WRITE : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == 4'd1) state_next = S_WRITE;
            end
            S_WRITE: begin
                done       = rst;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            flags         <= '0;
            alu_operation <= '0;
            alu_op1       <= '0;
            alu_op2       <= '0;
            wait_cnt      <= '0;
            dst_q         <= '0;
            wide_q        <= 1'b0;
            setf_q        <= 1'b0;
        end else begin
            state <= state_next;
            if (dbg_we) regs[dbg_wr_addr] <= dbg_wr_data;
            if (accept) begin
                alu_operation <= uop_op;
                alu_op1       <= src1_val;
                alu_op2       <= uop_imm_en ? uop_imm : src2_val;
                dst_q         <= uop_dst;
                wide_q        <= uop_wide;
                setf_q        <= uop_setf;
            end
            if (state == S_ISSUE) wait_cnt <= 4'(ALU_LAT - 1);
            else if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
            if (state == S_WRITE) begin
                regs[dst_q] <= alu_result_l;
                // Wide results spill into the next register, r7 wrapping to r0.
                if (wide_q) regs[dst_q + 3'd1] <= alu_result_h;
                if (setf_q) flags <= {alu_sign, alu_zero, alu_carry};
            end
        end
    end

endmodule
